// File: rtl/write_queue_drain.sv
// Consumer side of the 8-entry write queue: pops each 64-bit entry and retires it as one 32-bit memory write.
// Define WQ_DRAIN_TIMEOUT_EN to add a request timeout (TIMEOUT_CYCLES) that drops the write and pulses bus_err.
module write_queue_drain
`ifdef WQ_DRAIN_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wempty,
    input  logic [63:0] r_data,
    input  logic        hold,
    output logic        read,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        drained,
    output logic        busy
`ifdef WQ_DRAIN_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LOAD   = 3'd2,
        S_REQ    = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          start_c;
    logic          req_exit_c;

    // A new drain may start only when the queue has data and the arbiter allows it.
    assign start_c = !wempty && !hold;

`ifdef WQ_DRAIN_TIMEOUT_EN
    localparam int unsigned CW = 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout_c;

    // The request is abandoned on the cycle the wait count would reach TIMEOUT_CYCLES.
    assign timeout_c  = !mem_ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign req_exit_c = mem_ready || timeout_c;
    assign bus_err    = err_q;
`else
    assign req_exit_c = mem_ready;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef WQ_DRAIN_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_c) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                addr_d  = r_data[63:32];
                data_d  = r_data[31:0];
                state_d = S_REQ;
`ifdef WQ_DRAIN_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_REQ: begin
                if (req_exit_c) state_d = S_DONE;
`ifdef WQ_DRAIN_TIMEOUT_EN
                if (!mem_ready) cnt_d = cnt_q + CW'(1);
                err_d = timeout_c;
`endif
            end
            S_DONE: begin
                state_d = start_c ? S_SETTLE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        read    = 1'b0;
        mem_wen = 1'b0;
        busy    = (state_q != S_IDLE);
        drained = (state_q == S_IDLE) && wempty;
        case (state_q)
            S_LOAD:  read    = 1'b1;
            S_REQ:   mem_wen = 1'b1;
            default: ;
        endcase
    end

    // Address/data hold registers; stable for the whole request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

`ifdef WQ_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

endmodule

// File: tb/tb_write_queue_drain.sv
// Testbench for write_queue_drain: behavioural FIFO, write scoreboard, timing table and corner-case sequences.
`timescale 1ns/1ps
module tb_write_queue_drain;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        wempty    = 1'b1;
    logic [63:0] r_data    = '0;
    logic        hold      = 1'b0;
    logic        mem_ready = 1'b1;
    logic        read;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        drained;
    logic        busy;
    logic        push      = 1'b0;
    logic [63:0] push_data = '0;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int rd_cnt = 0;
    int wen_cnt = 0;
    int acc_cnt = 0;
    int err_cnt = 0;
    int acc_cyc[$];
    logic [63:0] fifo_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef WQ_DRAIN_TIMEOUT_EN
    localparam int unsigned TO = 4;
    logic bus_err;
    write_queue_drain #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .wempty(wempty), .r_data(r_data), .hold(hold),
        .read(read), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .drained(drained), .busy(busy), .bus_err(bus_err)
    );
`else
    write_queue_drain dut (
        .clk(clk), .reset(reset), .wempty(wempty), .r_data(r_data), .hold(hold),
        .read(read), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .drained(drained), .busy(busy)
    );
`endif

    // Behavioural write-queue FIFO: registered empty flag and head data.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_q.delete();
            wempty <= 1'b1;
            r_data <= '0;
        end else begin
            if (read && fifo_q.size() != 0) void'(fifo_q.pop_front());
            if (push) fifo_q.push_back(push_data);
            wempty <= (fifo_q.size() == 0);
            if (fifo_q.size() != 0) r_data <= fifo_q[0];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor and scoreboard, sampled mid-cycle.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;
    always @(negedge clk) begin
        if (reset) begin
            logic [63:0] e;
            if (read) begin
                rd_cnt++;
                if (wempty) check("read_while_empty", 64'(wempty), 64'd0);
            end
            if (mem_wen) wen_cnt++;
            if (prev_stall && mem_wen) begin
                check("stall_addr_stable", 64'(mem_addr), 64'(prev_addr));
                check("stall_data_stable", 64'(mem_wdata), 64'(prev_data));
            end
            if (mem_wen && mem_ready) begin
                acc_cnt++;
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_addr", 64'(mem_addr), 64'(e[63:32]));
                    check("sb_data", 64'(mem_wdata), 64'(e[31:0]));
                end
            end
`ifdef WQ_DRAIN_TIMEOUT_EN
            if (bus_err) begin
                err_cnt++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
`endif
            prev_stall = mem_wen && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // All sequence tasks start and end 1ns after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_entry(input logic [31:0] a, input logic [31:0] d);
        push      = 1'b1;
        push_data = {a, d};
        exp_q.push_back({a, d});
        step(1);
        push      = 1'b0;
    endtask

    task automatic wait_wen(input int bound);
        int i = 0;
        while (!mem_wen && i < bound) begin
            step(1);
            i++;
        end
        check("wait_mem_wen", 64'(mem_wen), 64'd1);
    endtask

    task automatic wait_drained(input int bound);
        int i = 0;
        while (!drained && i < bound) begin
            step(1);
            i++;
        end
        check("wait_drained", 64'(drained), 64'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        int          exp_wen_cycles;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int rd0, acc0, wen0, err0, n;

        vecs.push_back('{32'h0000_0040, 32'hDEAD_BEEF, 0, 1});
        vecs.push_back('{32'h0000_1000, 32'h1234_5678, 1, 2});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 3, 4});
        vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 2, 3});
        vecs.push_back('{32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, 1});
`ifndef WQ_DRAIN_TIMEOUT_EN
        vecs.push_back('{32'h0000_0080, 32'hCAFE_F00D, 5, 6});
`endif

        // Reset values.
        #2 reset = 1'b0;
        step(3);
        check("rst_read", 64'(read), 64'd0);
        check("rst_mem_wen", 64'(mem_wen), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_data", 64'(mem_wdata), 64'd0);
        check("rst_drained", 64'(drained), 64'd1);
        reset = 1'b1;
        step(2);
        check("idle_drained", 64'(drained), 64'd1);

        // Single-entry timing table: read at +2, write from +3, drained after DONE.
        foreach (vecs[v]) begin
            rd0  = rd_cnt;
            wen0 = wen_cnt;
            mem_ready = (vecs[v].stall == 0);
            push_entry(vecs[v].addr, vecs[v].data);
            for (int off = 0; off <= 6 + vecs[v].stall; off++) begin
                if (off == 3 + vecs[v].stall) mem_ready = 1'b1;
                check($sformatf("v%0d_read@%0d", v, off), 64'(read), 64'(off == 2));
                check($sformatf("v%0d_wen@%0d", v, off), 64'(mem_wen),
                      64'(off >= 3 && off <= 3 + vecs[v].stall));
                check($sformatf("v%0d_busy@%0d", v, off), 64'(busy),
                      64'(off >= 1 && off <= 4 + vecs[v].stall));
                check($sformatf("v%0d_drained@%0d", v, off), 64'(drained),
                      64'(off >= 5 + vecs[v].stall));
                if (off >= 3 && off <= 3 + vecs[v].stall) begin
                    check($sformatf("v%0d_addr@%0d", v, off), 64'(mem_addr), 64'(vecs[v].addr));
                    check($sformatf("v%0d_data@%0d", v, off), 64'(mem_wdata), 64'(vecs[v].data));
                end
                step(1);
            end
            check($sformatf("v%0d_reads", v), 64'(rd_cnt - rd0), 64'd1);
            check($sformatf("v%0d_wen_cycles", v), 64'(wen_cnt - wen0), 64'(vecs[v].exp_wen_cycles));
        end
        mem_ready = 1'b1;

        // Fill eight entries under hold, then drain back-to-back.
        hold = 1'b1;
        rd0  = rd_cnt;
        acc_cyc.delete();
        for (int i = 0; i < 8; i++) push_entry(32'(i), 32'(i * 3));
        check("fill_no_read", 64'(rd_cnt - rd0), 64'd0);
        hold = 1'b0;
        step(1);
        wait_drained(80);
        check("fill_writes", 64'(acc_cyc.size()), 64'd8);
        check("fill_reads", 64'(rd_cnt - rd0), 64'd8);
        check("fill_fifo_empty", 64'(fifo_q.size()), 64'd0);
        for (int i = 1; i < acc_cyc.size(); i++)
            check($sformatf("fill_spacing%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);

        // Hold blocks new drains; release drains three.
        hold = 1'b1;
        rd0  = rd_cnt;
        wen0 = wen_cnt;
        acc0 = acc_cnt;
        for (int i = 0; i < 3; i++) push_entry(32'h100 + 32'(i), 32'h5000 + 32'(i));
        step(5);
        check("hold_no_read", 64'(rd_cnt - rd0), 64'd0);
        check("hold_no_wen", 64'(wen_cnt - wen0), 64'd0);
        check("hold_not_busy", 64'(busy), 64'd0);
        hold = 1'b0;
        wait_drained(60);
        check("hold_release_writes", 64'(acc_cnt - acc0), 64'd3);
        check("hold_release_reads", 64'(rd_cnt - rd0), 64'd3);

        // Hold raised mid-request: current write completes, then idle.
        mem_ready = 1'b0;
        rd0  = rd_cnt;
        acc0 = acc_cnt;
        push_entry(32'h200, 32'hAAAA_0001);
        push_entry(32'h204, 32'hAAAA_0002);
        wait_wen(10);
        hold = 1'b1;
        step(2);
        check("holdreq_wen_kept", 64'(mem_wen), 64'd1);
        mem_ready = 1'b1;
        step(2);
        check("holdreq_idle", 64'(busy), 64'd0);
        step(4);
        check("holdreq_still_idle", 64'(busy), 64'd0);
        check("holdreq_reads", 64'(rd_cnt - rd0), 64'd1);
        check("holdreq_writes", 64'(acc_cnt - acc0), 64'd1);
        check("holdreq_fifo_left", 64'(fifo_q.size()), 64'd1);
        hold = 1'b0;
        wait_drained(30);
        check("holdreq_all_writes", 64'(acc_cnt - acc0), 64'd2);

        // Asynchronous reset mid-request.
        mem_ready = 1'b0;
        push_entry(32'h300, 32'hBBBB_0001);
        wait_wen(10);
        #2 reset = 1'b0;
        #1;
        check("arst_wen", 64'(mem_wen), 64'd0);
        check("arst_read", 64'(read), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_addr", 64'(mem_addr), 64'd0);
        check("arst_data", 64'(mem_wdata), 64'd0);
        check("arst_drained", 64'(drained), 64'd1);
        exp_q.delete();
        step(2);
        reset = 1'b1;
        mem_ready = 1'b1;
        step(2);
        check("post_rst_drained", 64'(drained), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);

`ifdef WQ_DRAIN_TIMEOUT_EN
        // Request timeout: first entry dropped with bus_err, second drains normally.
        mem_ready = 1'b0;
        err0 = err_cnt;
        acc0 = acc_cnt;
        push_entry(32'h400, 32'hCCCC_0001);
        push_entry(32'h404, 32'hCCCC_0002);
        wait_wen(10);
        n = 0;
        while (mem_wen && n < 20) begin
            n++;
            step(1);
        end
        check("to_req_cycles", 64'(n), 64'(TO));
        check("to_bus_err", 64'(bus_err), 64'd1);
        mem_ready = 1'b1;
        step(1);
        check("to_bus_err_pulse", 64'(bus_err), 64'd0);
        wait_drained(30);
        check("to_err_count", 64'(err_cnt - err0), 64'd1);
        check("to_next_write", 64'(acc_cnt - acc0), 64'd1);
`else
        n = 0;
        err0 = err_cnt;
        check("no_err_events", 64'(err_cnt - err0 + n), 64'd0);
`endif

        step(2);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
